lcd_unpacker: RTL
=================

Name: lcd_unpacker

Overview:
- Downstream stage of the HDMI ingest path. It reads 32-bit packed RGB words from the pixel FIFO and unpacks every 3 words into 4 pixels of 24 bits each, R in bits [23:16], G in [15:8], B in [7:0], MSB first.
- It drives the parallel LCD panel with locally generated hsync, vsync and data-enable timing.
- It sits on the FIFO read side, clocked by the LCD pixel clock.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch in clocks
- H_SYNC, 48, hsync pulse width in clocks
- H_BACK, 88, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 13, vertical front porch in lines
- V_SYNC, 3, vsync pulse width in lines
- V_BACK, 32, vertical back porch in lines

Ports:
- i_lcdClock  in  1  pixel clock; all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_fifoData  in  32  FIFO head word, first-word-fall-through; valid whenever i_fifoEmpty=0
- i_fifoEmpty  in  1  FIFO has no data
- o_fifoRead  out  1  pop the head word at this clock edge
- o_lcdData  out  24  pixel RGB, registered
- o_dataEnable  out  1  o_lcdData is a visible pixel, registered
- o_hSync  out  1  horizontal sync, active-low, registered
- o_vSync  out  1  vertical sync, active-low, registered
- o_underflow  out  1  sticky flag: FIFO was empty when a word was needed

Behaviour:
- Single clock domain, i_lcdClock. Reset is synchronous and active-high on i_reset.

Timing counters:
- H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK.
- V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK.
- hCount counts 0 to H_TOTAL-1 and wraps to 0.
- vCount increments when hCount wraps, and itself wraps to 0 after V_TOTAL-1.
- active = (hCount < H_ACTIVE) and (vCount < V_ACTIVE).
- hsync window: H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC.
- vsync window: V_ACTIVE+V_FRONT <= vCount < V_ACTIVE+V_FRONT+V_SYNC. vsync is line-granular and changes on the hCount wrap.
- Counter widths are sized from the parameters with $clog2.
- All LCD outputs are registered one cycle after the counter state. This 1-cycle latency applies equally to data, enable and syncs.

Unpack phase state machine (2-bit phase, plus 24-bit carry register):
- Phase 0: pixel = word[31:8]; carry[7:0] <= word[7:0]; pop.
- Phase 1: pixel = {carry[7:0], word[31:16]}; carry[15:0] <= word[15:0]; pop.
- Phase 2: pixel = {carry[15:0], word[31:24]}; carry[23:0] <= word[23:0]; pop.
- Phase 3: pixel = carry[23:0]; no pop.
- The phase advances modulo 4 only on a successfully produced pixel.

FIFO read rule:
- o_fifoRead = active and phase != 3 and not i_fifoEmpty and not i_reset.
- o_fifoRead is combinational.
- o_fifoRead is never high in blanking, in phase 3, or while the FIFO is empty.

Underflow (active, phase != 3, i_fifoEmpty = 1):
- No pop.
- o_lcdData = 0 (black), with o_dataEnable still 1.
- The phase and carry register hold.
- o_underflow is set and stays 1 until reset.
- Phase 3 never underflows.

Blanking:
- o_lcdData = 0 and o_dataEnable = 0.
- The phase and carry register hold across lines and frames; they are not realigned at frame start.

Reset values:
- hCount, vCount, phase and carry = 0.
- o_lcdData = 0, o_dataEnable = 0, o_hSync = 1, o_vSync = 1, o_underflow = 0, o_fifoRead = 0.

Reset mid-frame:
- Takes effect at the next edge.
- Timing restarts at pixel (0,0), so the first visible pixel appears on the outputs 1 cycle after reset is released.
- Any partially consumed word group is discarded: phase returns to 0 and the carry register clears.

Simultaneous events:
- When an hCount wrap and a vCount wrap coincide, both counters go to 0 in the same cycle.

Test Plan:
1. Unpack order:
   - Stimulus: reset released; FIFO holds 0x11223344, 0x55667788, 0x99AABBCC, with H_ACTIVE=4 and small porches.
   - Required: first line o_lcdData = 0x112233, 0x445566, 0x778899, 0xAABBCC with o_dataEnable=1; exactly 3 pops; no pop on the 4th pixel.
2. Timing:
   - Stimulus: H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_ACTIVE=2, V_FRONT=1, V_SYNC=1, V_BACK=1, continuous data.
   - Required: o_hSync low on output cycles 6-7 of every 8-clock line; o_vSync low for all of line 3 of each 5-line frame; o_dataEnable high for 4 clocks on lines 0-1 only.
3. Underflow:
   - Stimulus: FIFO empty from reset.
   - Required: o_fifoRead stays 0; o_lcdData=0 with o_dataEnable=1 on active pixels; o_underflow=1 after the first active cycle and stays 1.
   - Then load 0x11223344: next active pixel = 0x112233.
4. Blanking hold:
   - Stimulus: 6 words supplied, H_ACTIVE=2.
   - Required: pixels continue across lines with no realignment (line0: 0x112233, 0x445566; line1: 0x778899, 0xAABBCC); zero pops during blanking.
5. Mid-frame reset:
   - Stimulus: assert i_reset while in phase 2 on pixel 2.
   - Required: next edge gives o_hSync=1, o_vSync=1, o_dataEnable=0, o_underflow=0; after release the next word is unpacked from phase 0.
6. FIFO empty at word boundary:
   - Stimulus: empty asserted exactly on a phase-3 pixel.
   - Required: pixel = carry value, o_underflow stays 0, no pop.

Source files
------------

// File: rtl/lcd_unpacker.sv
// lcd_unpacker: pops 32-bit packed RGB words from a first-word-fall-through
// FIFO, unpacks each group of 3 words into 4 24-bit pixels and drives a
// parallel LCD with locally generated hsync/vsync/data-enable timing.
module lcd_unpacker #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 32
) (
  input  logic        i_lcdClock,
  input  logic        i_reset,
  input  logic [31:0] i_fifoData,
  input  logic        i_fifoEmpty,
  output logic        o_fifoRead,
  output logic [23:0] o_lcdData,
  output logic        o_dataEnable,
  output logic        o_hSync,
  output logic        o_vSync,
  output logic        o_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // One extra count of headroom so the sync-window end fits even with no back porch.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] r_h_count;
  logic [VW-1:0] r_v_count;
  logic [1:0]    r_phase;
  logic [23:0]   r_carry;

  logic          w_active;
  logic          w_hsync_win;
  logic          w_vsync_win;
  logic          w_need_word;
  logic          w_starved;
  logic          w_pixel_ok;
  logic [23:0]   w_pixel;
  logic [23:0]   w_carry_next;

  assign w_active    = (r_h_count < H_ACT_END) && (r_v_count < V_ACT_END);
  assign w_hsync_win = (r_h_count >= HS_START) && (r_h_count < HS_END);
  assign w_vsync_win = (r_v_count >= VS_START) && (r_v_count < VS_END);

  // Phase 3 is served entirely from the carry, so it never touches the FIFO.
  assign w_need_word = (r_phase != 2'd3);
  assign w_starved   = w_active && w_need_word && i_fifoEmpty;
  assign w_pixel_ok  = w_active && !w_starved;
  assign o_fifoRead  = w_active && w_need_word && !i_fifoEmpty && !i_reset;

  // Select the pixel bytes for the current phase and the carry bytes left over.
  always_comb begin
    w_pixel      = r_carry;
    w_carry_next = r_carry;
    unique case (r_phase)
      2'd0: begin
        w_pixel      = i_fifoData[31:8];
        w_carry_next = {r_carry[23:8], i_fifoData[7:0]};
      end
      2'd1: begin
        w_pixel      = {r_carry[7:0], i_fifoData[31:16]};
        w_carry_next = {r_carry[23:16], i_fifoData[15:0]};
      end
      2'd2: begin
        w_pixel      = {r_carry[15:0], i_fifoData[31:24]};
        w_carry_next = i_fifoData[23:0];
      end
      default: begin
        w_pixel      = r_carry;
        w_carry_next = r_carry;
      end
    endcase
  end

  // Raster counters: hCount wraps each line, vCount steps on that wrap.
  always_ff @(posedge i_lcdClock) begin
    if (i_reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (r_h_count == H_LAST) begin
      r_h_count <= '0;
      r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 1'b1;
    end else begin
      r_h_count <= r_h_count + 1'b1;
    end
  end

  // Unpack phase and carry only move on a pixel actually produced; blanking
  // and starved cycles hold them, so word groups straddle lines and frames.
  always_ff @(posedge i_lcdClock) begin
    if (i_reset) begin
      r_phase <= 2'd0;
      r_carry <= '0;
    end else if (w_pixel_ok) begin
      r_phase <= r_phase + 2'd1;
      r_carry <= w_carry_next;
    end
  end

  // Registered panel outputs, one cycle behind the counter state.
  always_ff @(posedge i_lcdClock) begin
    if (i_reset) begin
      o_lcdData    <= '0;
      o_dataEnable <= 1'b0;
      o_hSync      <= 1'b1;
      o_vSync      <= 1'b1;
      o_underflow  <= 1'b0;
    end else begin
      o_lcdData    <= w_pixel_ok ? w_pixel : 24'h0;
      o_dataEnable <= w_active;
      o_hSync      <= !w_hsync_win;
      o_vSync      <= !w_vsync_win;
      if (w_starved) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule
